// File: rtl/n101_pwm16_icb_regs_pkg.sv
// Shared register map for the n101_pwm16 ICB bridge: word offsets, register index, helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package n101_pwm16_icb_regs_pkg;

  // Byte offsets of the mapped core registers.
  localparam logic [31:0] OFF_CFG     = 32'h00;
  localparam logic [31:0] OFF_COUNTLO = 32'h08;
  localparam logic [31:0] OFF_COUNTHI = 32'h0C;
  localparam logic [31:0] OFF_S       = 32'h10;
  localparam logic [31:0] OFF_CMP0    = 32'h20;
  localparam logic [31:0] OFF_CMP1    = 32'h24;
  localparam logic [31:0] OFF_CMP2    = 32'h28;
  localparam logic [31:0] OFF_CMP3    = 32'h2C;

  // Register index. REG_NONE marks any offset that does not hit a mapped register;
  // feed and key are deliberately absent because they are not bus-visible.
  typedef enum logic [3:0] {
    REG_CFG     = 4'd0,
    REG_COUNTLO = 4'd1,
    REG_COUNTHI = 4'd2,
    REG_S       = 4'd3,
    REG_CMP0    = 4'd4,
    REG_CMP1    = 4'd5,
    REG_CMP2    = 4'd6,
    REG_CMP3    = 4'd7,
    REG_NONE    = 4'd15
  } reg_idx_e;

  // Exact-match decode; misaligned offsets never match an entry.
  function automatic reg_idx_e decode_offset(input logic [31:0] addr);
    case (addr)
      OFF_CFG:     return REG_CFG;
      OFF_COUNTLO: return REG_COUNTLO;
      OFF_COUNTHI: return REG_COUNTHI;
      OFF_S:       return REG_S;
      OFF_CMP0:    return REG_CMP0;
      OFF_CMP1:    return REG_CMP1;
      OFF_CMP2:    return REG_CMP2;
      OFF_CMP3:    return REG_CMP3;
      default:     return REG_NONE;
    endcase
  endfunction

  // Expand a 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
    return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  endfunction

endpackage

// File: rtl/n101_pwm16_rsp_buf.sv
// Single-entry ICB response buffer: valid/rdata/err registers and cmd_ready derivation.
// Latency: response valid the cycle after i_load.
// Backpressure: holds contents while o_rsp_valid & !i_rsp_ready; o_cmd_ready drops in that state.
//
// Ports: clk/rst_n; i_load (command accepted), i_rdata/i_err (response to capture),
// i_rsp_ready (master ready); o_rsp_valid/o_rsp_rdata/o_rsp_err (buffered response),
// o_cmd_ready (room for a new command).
module n101_pwm16_rsp_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_rdata,
  input  logic        i_err,
  input  logic        i_rsp_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_cmd_ready
);

  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  // Room exists when empty or when the held response leaves this cycle.
  assign o_cmd_ready = !r_valid || i_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_rdata <= i_rdata;
      r_err   <= i_err;
    end else if (i_rsp_ready) begin
      // Data/err are left as-is; only valid drops once the response is taken.
      r_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule

// File: rtl/n101_pwm16_icb_regs.sv
// ICB slave register bridge for n101_pwm16_core: decodes single-beat commands to write strobes, muxes reads.
// Latency: write strobes combinational in the accept cycle; response valid one cycle after accept.
// Backpressure: one buffered response; i_icb_cmd_ready low while a response is stalled.
//
// Ports: clk/rst_n; ICB command (i_icb_cmd_*) and response (i_icb_rsp_*) channels;
// per-register o_<reg>_write_valid/o_<reg>_write_bits strobes and i_<reg>_read values
// for cfg, countLo, countHi, s, cmp_0..cmp_3, feed, key.
// Optional macro N101_PWM16_ICB_WMASK_EN: byte-merge writes using wmask against the
// current register value; when undefined writes are full-word.
module n101_pwm16_icb_regs
  import n101_pwm16_icb_regs_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          i_icb_cmd_valid,
  output logic          i_icb_cmd_ready,
  input  logic [AW-1:0] i_icb_cmd_addr,
  input  logic          i_icb_cmd_read,
  input  logic [31:0]   i_icb_cmd_wdata,
  input  logic [3:0]    i_icb_cmd_wmask,
  output logic          i_icb_rsp_valid,
  input  logic          i_icb_rsp_ready,
  output logic [31:0]   i_icb_rsp_rdata,
  output logic          i_icb_rsp_err,

  output logic          o_cfg_write_valid,
  output logic [31:0]   o_cfg_write_bits,
  input  logic [31:0]   i_cfg_read,
  output logic          o_countLo_write_valid,
  output logic [31:0]   o_countLo_write_bits,
  input  logic [31:0]   i_countLo_read,
  output logic          o_countHi_write_valid,
  output logic [31:0]   o_countHi_write_bits,
  input  logic [31:0]   i_countHi_read,
  output logic          o_s_write_valid,
  output logic [15:0]   o_s_write_bits,
  input  logic [15:0]   i_s_read,
  output logic          o_cmp_0_write_valid,
  output logic [15:0]   o_cmp_0_write_bits,
  input  logic [15:0]   i_cmp_0_read,
  output logic          o_cmp_1_write_valid,
  output logic [15:0]   o_cmp_1_write_bits,
  input  logic [15:0]   i_cmp_1_read,
  output logic          o_cmp_2_write_valid,
  output logic [15:0]   o_cmp_2_write_bits,
  input  logic [15:0]   i_cmp_2_read,
  output logic          o_cmp_3_write_valid,
  output logic [15:0]   o_cmp_3_write_bits,
  input  logic [15:0]   i_cmp_3_read,
  output logic          o_feed_write_valid,
  output logic [31:0]   o_feed_write_bits,
  input  logic [31:0]   i_feed_read,
  output logic          o_key_write_valid,
  output logic [31:0]   o_key_write_bits,
  input  logic [31:0]   i_key_read
);

  logic [31:0] w_addr32;
  reg_idx_e    w_idx;
  logic        w_cmd_ready;
  logic        w_accept;
  logic        w_err;
  logic        w_wr_fire;
  logic [31:0] w_rd_sel;
  logic [31:0] w_rsp_rdata;
  logic [31:0] w_wr_bits;
  logic        w_unused_reads;

  assign w_addr32 = 32'(i_icb_cmd_addr);
  assign w_idx    = decode_offset(w_addr32);

  // Gating with rst_n keeps strobes quiet while reset is held, even though
  // cmd_ready reads 1 out of reset.
  assign w_accept = rst_n && i_icb_cmd_valid && w_cmd_ready;

  assign w_err = (w_idx == REG_NONE)
              || (w_addr32[1:0] != 2'b00)
              || (!i_icb_cmd_read && ((w_idx == REG_S) || (i_icb_cmd_wmask == 4'h0)));

  // Read mux: current core value, zero-extended. Sampled in the accept cycle,
  // so it reflects state before any write accepted in that same cycle.
  always_comb begin
    w_rd_sel = 32'h0;
    case (w_idx)
      REG_CFG:     w_rd_sel = i_cfg_read;
      REG_COUNTLO: w_rd_sel = i_countLo_read;
      REG_COUNTHI: w_rd_sel = i_countHi_read;
      REG_S:       w_rd_sel = {16'h0, i_s_read};
      REG_CMP0:    w_rd_sel = {16'h0, i_cmp_0_read};
      REG_CMP1:    w_rd_sel = {16'h0, i_cmp_1_read};
      REG_CMP2:    w_rd_sel = {16'h0, i_cmp_2_read};
      REG_CMP3:    w_rd_sel = {16'h0, i_cmp_3_read};
      default:     w_rd_sel = 32'h0;
    endcase
  end

  // Writes and errored accesses both answer with zero data.
  assign w_rsp_rdata = (i_icb_cmd_read && !w_err) ? w_rd_sel : 32'h0;

`ifdef N101_PWM16_ICB_WMASK_EN
  // Disabled bytes keep the register's current value.
  assign w_wr_bits = (i_icb_cmd_wdata & byte_mask(i_icb_cmd_wmask))
                   | (w_rd_sel & ~byte_mask(i_icb_cmd_wmask));
`else
  assign w_wr_bits = i_icb_cmd_wdata;
`endif

  assign w_wr_fire = w_accept && !i_icb_cmd_read && !w_err;

  // One-hot by construction: a single decoded index per cycle.
  assign o_cfg_write_valid     = w_wr_fire && (w_idx == REG_CFG);
  assign o_countLo_write_valid = w_wr_fire && (w_idx == REG_COUNTLO);
  assign o_countHi_write_valid = w_wr_fire && (w_idx == REG_COUNTHI);
  assign o_cmp_0_write_valid   = w_wr_fire && (w_idx == REG_CMP0);
  assign o_cmp_1_write_valid   = w_wr_fire && (w_idx == REG_CMP1);
  assign o_cmp_2_write_valid   = w_wr_fire && (w_idx == REG_CMP2);
  assign o_cmp_3_write_valid   = w_wr_fire && (w_idx == REG_CMP3);
  // s is read-only and feed/key are not bus-mapped.
  assign o_s_write_valid       = 1'b0;
  assign o_feed_write_valid    = 1'b0;
  assign o_key_write_valid     = 1'b0;

  assign o_cfg_write_bits      = w_wr_bits;
  assign o_countLo_write_bits  = w_wr_bits;
  assign o_countHi_write_bits  = w_wr_bits;
  assign o_s_write_bits        = w_wr_bits[15:0];
  assign o_cmp_0_write_bits    = w_wr_bits[15:0];
  assign o_cmp_1_write_bits    = w_wr_bits[15:0];
  assign o_cmp_2_write_bits    = w_wr_bits[15:0];
  assign o_cmp_3_write_bits    = w_wr_bits[15:0];
  assign o_feed_write_bits     = 32'h0;
  assign o_key_write_bits      = 32'h0;

  assign w_unused_reads = ^{i_feed_read, i_key_read};

  n101_pwm16_rsp_buf u_rsp_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_rdata     (w_rsp_rdata),
    .i_err       (w_err),
    .i_rsp_ready (i_icb_rsp_ready),
    .o_rsp_valid (i_icb_rsp_valid),
    .o_rsp_rdata (i_icb_rsp_rdata),
    .o_rsp_err   (i_icb_rsp_err),
    .o_cmd_ready (w_cmd_ready)
  );

  assign i_icb_cmd_ready = w_cmd_ready;

endmodule

// File: tb/tb_n101_pwm16_icb_regs.sv
// Directed bench for n101_pwm16_icb_regs with a response scoreboard and a small core-register model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_n101_pwm16_icb_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        cfg_wv, clo_wv, chi_wv, s_wv, c0_wv, c1_wv, c2_wv, c3_wv, feed_wv, key_wv;
  logic [31:0] cfg_wb, clo_wb, chi_wb, feed_wb, key_wb;
  logic [15:0] s_wb, c0_wb, c1_wb, c2_wb, c3_wb;

  // Core register model: updated by the bridge's strobes like the real core.
  logic [31:0] cfg_q = 32'h0;
  logic [31:0] clo_q = 32'h0;
  logic [31:0] chi_q = 32'h0;
  logic [15:0] s_q   = 16'h5A5A;
  logic [15:0] c0_q  = 16'h0;
  logic [15:0] c1_q  = 16'h0;
  logic [15:0] c2_q  = 16'h0;
  logic [15:0] c3_q  = 16'h0;

  always @(posedge clk) begin
    if (cfg_wv) cfg_q <= cfg_wb;
    if (clo_wv) clo_q <= clo_wb;
    if (c0_wv)  c0_q  <= c0_wb;
    if (c1_wv)  c1_q  <= c1_wb;
    if (c2_wv)  c2_q  <= c2_wb;
    if (c3_wv)  c3_q  <= c3_wb;
  end

  n101_pwm16_icb_regs #(.AW(12)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_icb_cmd_valid       (cmd_valid),
    .i_icb_cmd_ready       (cmd_ready),
    .i_icb_cmd_addr        (cmd_addr),
    .i_icb_cmd_read        (cmd_read),
    .i_icb_cmd_wdata       (cmd_wdata),
    .i_icb_cmd_wmask       (cmd_wmask),
    .i_icb_rsp_valid       (rsp_valid),
    .i_icb_rsp_ready       (rsp_ready),
    .i_icb_rsp_rdata       (rsp_rdata),
    .i_icb_rsp_err         (rsp_err),
    .o_cfg_write_valid     (cfg_wv),
    .o_cfg_write_bits      (cfg_wb),
    .i_cfg_read            (cfg_q),
    .o_countLo_write_valid (clo_wv),
    .o_countLo_write_bits  (clo_wb),
    .i_countLo_read        (clo_q),
    .o_countHi_write_valid (chi_wv),
    .o_countHi_write_bits  (chi_wb),
    .i_countHi_read        (chi_q),
    .o_s_write_valid       (s_wv),
    .o_s_write_bits        (s_wb),
    .i_s_read              (s_q),
    .o_cmp_0_write_valid   (c0_wv),
    .o_cmp_0_write_bits    (c0_wb),
    .i_cmp_0_read          (c0_q),
    .o_cmp_1_write_valid   (c1_wv),
    .o_cmp_1_write_bits    (c1_wb),
    .i_cmp_1_read          (c1_q),
    .o_cmp_2_write_valid   (c2_wv),
    .o_cmp_2_write_bits    (c2_wb),
    .i_cmp_2_read          (c2_q),
    .o_cmp_3_write_valid   (c3_wv),
    .o_cmp_3_write_bits    (c3_wb),
    .i_cmp_3_read          (c3_q),
    .o_feed_write_valid    (feed_wv),
    .o_feed_write_bits     (feed_wb),
    .i_feed_read           (32'hFEEDFEED),
    .o_key_write_valid     (key_wv),
    .o_key_write_bits      (key_wb),
    .i_key_read            (32'h0BADC0DE)
  );

  always #5 clk = ~clk;

  // Strobe index: 0 cfg, 1 countLo, 2 countHi, 3 s, 4..7 cmp_0..3, 8 feed, 9 key.
  wire [9:0] stb_vec = {key_wv, feed_wv, c3_wv, c2_wv, c1_wv, c0_wv, s_wv, chi_wv, clo_wv, cfg_wv};

  function automatic logic [31:0] stb_bits(input int i);
    case (i)
      0:       return cfg_wb;
      1:       return clo_wb;
      2:       return chi_wb;
      3:       return {16'h0, s_wb};
      4:       return {16'h0, c0_wb};
      5:       return {16'h0, c1_wb};
      6:       return {16'h0, c2_wb};
      7:       return {16'h0, c3_wb};
      8:       return feed_wb;
      default: return key_wb;
    endcase
  endfunction

`ifdef N101_PWM16_ICB_WMASK_EN
  localparam logic [31:0] MERGE_EXP = 32'hAABB33DD;
`else
  localparam logic [31:0] MERGE_EXP = 32'h11223344;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cyc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: every response handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("rsp_unexpected", $sformatf("response 0x%08h err=%0b with no expectation", rsp_rdata, rsp_err));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        rsp_cyc_q.push_back(cyc);
      end
    end
  end

  // Drive one command, push its expected response and check the strobes in the accept cycle.
  task automatic issue(input string name, input logic rd, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm, input int exp_idx,
                       input logic [31:0] exp_bits, input logic [31:0] exp_rdata, input logic exp_err);
    logic acc;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wmask = wm;
    exp_q.push_back('{exp_rdata, exp_err});
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1'b1;
        check({name, "_stb"}, {22'h0, stb_vec}, (exp_idx < 0) ? 32'h0 : (32'h1 << exp_idx));
        if (exp_idx >= 0) check({name, "_bits"}, stb_bits(exp_idx), exp_bits);
      end
      @(posedge clk); #1;
    end
    if (!acc) fail_now(name, "command not accepted within 20 cycles");
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) fail_now(name, $sformatf("%0d responses still outstanding", exp_q.size()));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 12'h0;
    cmd_read  = 1'b0;
    cmd_wdata = 32'h0;
    cmd_wmask = 4'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_strobes", {22'h0, stb_vec}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk); #1;

    // Write cmp_1 then read it back on the next cycle
    issue("wr_cmp1", 1'b0, 12'h024, 32'h0000_1234, 4'hF, 5, 32'h0000_1234, 32'h0, 1'b0);
    issue("rd_cmp1", 1'b1, 12'h024, 32'h0, 4'h0, -1, 32'h0, 32'h0000_1234, 1'b0);
    wait_drain("drain_cmp1");

    // Error cases: unmapped, misaligned, out of range, write to s, empty wmask
    issue("rd_04",    1'b1, 12'h004, 32'h0, 4'h0, -1, 32'h0, 32'h0, 1'b1);
    issue("rd_22",    1'b1, 12'h022, 32'h0, 4'h0, -1, 32'h0, 32'h0, 1'b1);
    issue("rd_30",    1'b1, 12'h030, 32'h0, 4'h0, -1, 32'h0, 32'h0, 1'b1);
    issue("wr_s",     1'b0, 12'h010, 32'hDEAD_BEEF, 4'hF, -1, 32'h0, 32'h0, 1'b1);
    issue("wr_mask0", 1'b0, 12'h000, 32'h1111_1111, 4'h0, -1, 32'h0, 32'h0, 1'b1);
    issue("rd_s",     1'b1, 12'h010, 32'h0, 4'h0, -1, 32'h0, 32'h0000_5A5A, 1'b0);
    issue("wr_chi",   1'b0, 12'h00C, 32'hCAFE_F00D, 4'hF, 2, 32'hCAFE_F00D, 32'h0, 1'b0);

    // Populate registers; cmp_3 write checks truncation to 16 bits
    issue("wr_cfg",   1'b0, 12'h000, 32'hAABB_CCDD, 4'hF, 0, 32'hAABB_CCDD, 32'h0, 1'b0);
    issue("wr_cmp0",  1'b0, 12'h020, 32'h0000_00A5, 4'hF, 4, 32'h0000_00A5, 32'h0, 1'b0);
    issue("wr_cmp3",  1'b0, 12'h02C, 32'h0001_BEEF, 4'hF, 7, 32'h0000_BEEF, 32'h0, 1'b0);
    wait_drain("drain_setup");

    // Back-to-back reads on consecutive cycles
    rsp_cyc_q.delete();
    issue("b2b_cfg",  1'b1, 12'h000, 32'h0, 4'h0, -1, 32'h0, 32'hAABB_CCDD, 1'b0);
    issue("b2b_cmp0", 1'b1, 12'h020, 32'h0, 4'h0, -1, 32'h0, 32'h0000_00A5, 1'b0);
    issue("b2b_cmp3", 1'b1, 12'h02C, 32'h0, 4'h0, -1, 32'h0, 32'h0000_BEEF, 1'b0);
    wait_drain("drain_b2b");
    if (rsp_cyc_q.size() == 3) begin
      check("b2b_gap1", rsp_cyc_q[1] - rsp_cyc_q[0], 32'd1);
      check("b2b_gap2", rsp_cyc_q[2] - rsp_cyc_q[1], 32'd1);
    end else begin
      fail_now("b2b_count", $sformatf("saw %0d responses, expected 3", rsp_cyc_q.size()));
    end

    // Stalled response holds off the next command
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue("stall_rd", 1'b1, 12'h024, 32'h0, 4'h0, -1, 32'h0, 32'h0000_1234, 1'b0);
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    cmd_addr  = 12'h020;
    exp_q.push_back('{32'h0000_00A5, 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall_rdata", rsp_rdata, 32'h0000_1234);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_drain("drain_stall");

    // Byte-masked write to cfg, then read back what the core latched
    issue("wr_merge", 1'b0, 12'h000, 32'h1122_3344, 4'b0010, 0, MERGE_EXP, 32'h0, 1'b0);
    issue("rd_merge", 1'b1, 12'h000, 32'h0, 4'h0, -1, 32'h0, MERGE_EXP, 1'b0);
    wait_drain("drain_merge");

    // Reset during a pending response drops it; no strobe while reset is low
    rsp_ready = 1'b0;
    issue("rst_pend", 1'b1, 12'h024, 32'h0, 4'h0, -1, 32'h0, 32'h0000_1234, 1'b0);
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_read  = 1'b0;
    cmd_addr  = 12'h020;
    cmd_wdata = 32'h0000_7777;
    cmd_wmask = 4'hF;
    #1;
    check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_strobes", {22'h0, stb_vec}, 32'h0);
    check("mid_rst_rdata", rsp_rdata, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    issue("post_rst_rd", 1'b1, 12'h020, 32'h0, 4'h0, -1, 32'h0, 32'h0000_00A5, 1'b0);
    wait_drain("drain_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
